sf_camera_emitter: RTL and testbench
====================================

# sf_camera_emitter

Camera-side pixel source for the sf_camera path: consumes 32-bit words from a ping-pong FIFO read port and drives a parallel camera bus (pixel clock, vsync, hsync, 8-bit data) frame by frame. It is the transmit counterpart to the sf_camera receive path. It serves as a bench/loopback source and as a sensor emulator on boards without a camera. All logic runs in one clock domain; the output pixel clock is derived from it.

## Interface
- PIXEL_COUNT, 8: bytes per row. Must be a multiple of 4 and ≥ 4.
- ROW_COUNT, 2: rows per frame, ≥ 1.
- HBLANK, 4: idle pixel periods between rows, ≥ 1.
- VBLANK, 8: idle pixel periods before each frame, ≥ 1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_enable  in  1  level; run continuous frames while high.
- i_reset_counts  in  1  pulse; clears o_frame_count and o_underrun.
- o_busy  out  1  high from leaving IDLE until return to IDLE.
- o_underrun  out  1  sticky; FIFO had no word when a byte was due.
- o_frame_count  out  32  frames completed.
- i_rfifo_ready  in  1  a FIFO block is available.
- o_rfifo_activate  out  1  block owned by this emitter.
- o_rfifo_strobe  out  1  one-cycle pop of the current word.
- i_rfifo_data  in  32  current word; valid while activated, next word valid 1 clk after strobe.
- i_rfifo_size  in  24  words in the owned block, sampled at activate.
- o_pix_clk  out  1  clk/2 pixel clock.
- o_vsync  out  1  high across the active frame.
- o_hsync  out  1  high while o_pix_data is a valid row byte.
- o_pix_data  out  8  pixel byte.

## Operation
- States:
  - IDLE → VBLANK when i_enable is high.
  - VBLANK (VBLANK periods) → ROW.
  - ROW (PIXEL_COUNT periods) → HBLANK if rows remain; otherwise → FRAME_END.
  - HBLANK (HBLANK periods) → ROW.
  - FRAME_END increments o_frame_count, then → VBLANK if i_enable is high, else → IDLE.
- i_enable falling mid-frame: the current frame completes; there is no truncation.
- o_vsync rises with the first ROW byte of the frame and falls after the last byte of the last row.
- o_hsync is high exactly during ROW periods.
- Byte order: bits [31:24] of each word are sent first, then [23:16], [15:8], [7:0].
- FIFO consumer:
  - When not activated and i_rfifo_ready is high, assert o_rfifo_activate and latch i_rfifo_size.
  - Hold a one-word prefetch register; strobe when that register is empty and the block is not exhausted.
  - Deassert o_rfifo_activate the cycle after the strobe that consumes the last word (count == size).
  - A block may span rows and frames. A size of 0 releases the block immediately.
- Underrun (no word available when a byte is due in ROW): emit 0x00, keep o_hsync high, set o_underrun. Timing never stalls.
- Blanking periods: o_pix_data = 0x00.

## Timing
- Reset values:
  - outputs: all 0.
  - state: IDLE.
  - o_pix_clk phase: 0.
- o_pix_clk toggles every clk while state ≠ IDLE and holds 0 in IDLE. One pixel period = 2 clk.
- o_pix_data, o_hsync and o_vsync change only on the clk where o_pix_clk goes 1→0. They are stable across the following rising edge of o_pix_clk.
- Latency: i_enable high to first ROW byte = 1 + 2·VBLANK clk, provided the prefetch is already full.
- Strobe rate: at most one strobe per 8 clk during ROW. Prefetch refill completes within 2 clk of the word being consumed.
- Simultaneous i_reset_counts and FRAME_END: the clear wins, and o_frame_count = 0.
- Async reset mid-row: all outputs go to 0 immediately; o_rfifo_activate drops with them, and the block is abandoned.

## Structure
- Package sf_camera_emitter_pkg holds:
  - the state encoding (IDLE, VBLANK, ROW, HBLANK, FRAME_END);
  - counter-width functions (clog2 of PIXEL_COUNT, ROW_COUNT, max(HBLANK, VBLANK)).
- Sub-module sf_camera_word_feeder contains:
  - the FIFO activate/strobe/count logic;
  - the prefetch register and byte serializer;
  - interface: a byte request in, then byte and underrun flag out.
- The top level holds the timing FSM, the pixel-clock phase, and the counters.

## Test plan
- Single frame, default parameters, block of 4 words 0x00010203…0x0C0D0E0F, i_enable dropped after start:
  - bytes 00..07 on row 0 and 08..0F on row 1;
  - hsync low for exactly 4 pixel periods between rows;
  - o_frame_count = 1; return to IDLE.
- Two-block frame, sizes 1 and 3: byte stream is identical to the single-block case, and o_rfifo_activate pulses twice.
- Empty FIFO (i_rfifo_ready low):
  - 16 bytes of 0x00 with correct hsync/vsync framing;
  - o_underrun = 1;
  - i_reset_counts then clears o_underrun and o_frame_count.
- Continuous i_enable over 3 frames with an ample FIFO: 3 vsync pulses separated by 8 blank periods; o_frame_count = 3.
- rst asserted mid-row 1:
  - all outputs go to 0 asynchronously;
  - after release with i_enable high, the next frame starts from VBLANK with a fresh activate.
- Size-0 block:
  - activate is held for 1 cycle with no strobe;
  - the next ready block is consumed normally.

Source files
------------

// File: rtl/sf_camera_emitter_pkg.sv
// Shared types and sizing helpers for the camera emitter: FSM state encoding,
// bus widths and counter-width functions derived from the frame geometry.
package sf_camera_emitter_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned SIZE_W  = 24;
    localparam int unsigned FRAME_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VBLANK,
        ST_ROW,
        ST_HBLANK,
        ST_FRAME_END
    } state_e;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned pix_cnt_w(input int unsigned pixel_count);
        return cnt_w(pixel_count);
    endfunction

    function automatic int unsigned row_cnt_w(input int unsigned row_count);
        return cnt_w(row_count);
    endfunction

    function automatic int unsigned blank_cnt_w(input int unsigned hblank, input int unsigned vblank);
        return cnt_w((hblank > vblank) ? hblank : vblank);
    endfunction

endpackage

// File: rtl/sf_camera_word_feeder.sv
// FIFO block consumer for the camera emitter: owns a FIFO block, keeps one
// prefetched word and hands out its bytes MSB first on request.
module sf_camera_word_feeder
    import sf_camera_emitter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_req,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_underrun,
    input  logic              i_rfifo_ready,
    output logic              o_rfifo_activate,
    output logic              o_rfifo_strobe,
    input  logic [WORD_W-1:0] i_rfifo_data,
    input  logic [SIZE_W-1:0] i_rfifo_size
);

    logic              active_q, active_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] count_q, count_d;
    logic              pf_valid_q, pf_valid_d;
    logic [WORD_W-1:0] pf_word_q, pf_word_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic              strobe;

    always_comb begin
        active_d   = active_q;
        size_d     = size_q;
        count_d    = count_q;
        pf_valid_d = pf_valid_q;
        pf_word_d  = pf_word_q;
        byte_idx_d = byte_idx_q;

        // Pop only into an empty prefetch, so pops are spaced a full word apart.
        strobe = active_q && !pf_valid_q && (count_q != size_q);

        if (!active_q) begin
            if (i_rfifo_ready) begin
                active_d = 1'b1;
                size_d   = i_rfifo_size;
                count_d  = '0;
            end
        end else if (count_q == size_q) begin
            active_d = 1'b0;
        end else if (strobe) begin
            count_d = count_q + 24'd1;
            if ((count_q + 24'd1) == size_q) begin
                active_d = 1'b0;
            end
        end

        if (strobe) begin
            pf_valid_d = 1'b1;
            pf_word_d  = i_rfifo_data;
        end else if (byte_req && pf_valid_q) begin
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
                pf_valid_d = 1'b0;
            end
        end

        byte_data = '0;
        if (pf_valid_q) begin
            case (byte_idx_q)
                2'd0:    byte_data = pf_word_q[31:24];
                2'd1:    byte_data = pf_word_q[23:16];
                2'd2:    byte_data = pf_word_q[15:8];
                default: byte_data = pf_word_q[7:0];
            endcase
        end
        byte_underrun = byte_req && !pf_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            size_q     <= '0;
            count_q    <= '0;
            pf_valid_q <= 1'b0;
            pf_word_q  <= '0;
            byte_idx_q <= '0;
        end else begin
            active_q   <= active_d;
            size_q     <= size_d;
            count_q    <= count_d;
            pf_valid_q <= pf_valid_d;
            pf_word_q  <= pf_word_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    assign o_rfifo_activate = active_q;
    assign o_rfifo_strobe   = strobe;

endmodule

// File: rtl/sf_camera_emitter.sv
// Parallel camera bus source: frame/row timing FSM, clk/2 pixel clock and
// frame counters, fed bytes by sf_camera_word_feeder.
module sf_camera_emitter
    import sf_camera_emitter_pkg::*;
#(
    parameter int unsigned PIXEL_COUNT = 8,
    parameter int unsigned ROW_COUNT   = 2,
    parameter int unsigned HBLANK      = 4,
    parameter int unsigned VBLANK      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enable,
    input  logic               i_reset_counts,
    output logic               o_busy,
    output logic               o_underrun,
    output logic [FRAME_W-1:0] o_frame_count,
    input  logic               i_rfifo_ready,
    output logic               o_rfifo_activate,
    output logic               o_rfifo_strobe,
    input  logic [WORD_W-1:0]  i_rfifo_data,
    input  logic [SIZE_W-1:0]  i_rfifo_size,
    output logic               o_pix_clk,
    output logic               o_vsync,
    output logic               o_hsync,
    output logic [BYTE_W-1:0]  o_pix_data
);

    localparam int unsigned PW = pix_cnt_w(PIXEL_COUNT);
    localparam int unsigned RW = row_cnt_w(ROW_COUNT);
    localparam int unsigned BW = blank_cnt_w(HBLANK, VBLANK);

    localparam logic [PW-1:0] PIX_LAST = PW'(PIXEL_COUNT - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW_COUNT - 1);
    localparam logic [BW-1:0] HB_LAST  = BW'(HBLANK - 1);
    localparam logic [BW-1:0] VB_LAST  = BW'(VBLANK - 1);

    state_e             state_q, state_d;
    logic               pix_clk_q, pix_clk_d;
    logic [PW-1:0]      pix_cnt_q, pix_cnt_d;
    logic [RW-1:0]      row_cnt_q, row_cnt_d;
    logic [BW-1:0]      blank_cnt_q, blank_cnt_d;
    logic               vsync_q, vsync_d;
    logic               hsync_q, hsync_d;
    logic [BYTE_W-1:0]  pix_data_q, pix_data_d;
    logic               underrun_q, underrun_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    logic               tick;
    logic               byte_req;
    logic               frame_inc;
    logic [BYTE_W-1:0]  feed_byte;
    logic               feed_underrun;

    sf_camera_word_feeder u_feeder (
        .clk              (clk),
        .rst_n            (rst),
        .byte_req         (byte_req),
        .byte_data        (feed_byte),
        .byte_underrun    (feed_underrun),
        .i_rfifo_ready    (i_rfifo_ready),
        .o_rfifo_activate (o_rfifo_activate),
        .o_rfifo_strobe   (o_rfifo_strobe),
        .i_rfifo_data     (i_rfifo_data),
        .i_rfifo_size     (i_rfifo_size)
    );

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        row_cnt_d   = row_cnt_q;
        blank_cnt_d = blank_cnt_q;
        vsync_d     = vsync_q;
        hsync_d     = hsync_q;
        pix_data_d  = pix_data_q;
        byte_req    = 1'b0;
        frame_inc   = 1'b0;

        // Every bus update happens on the pixel clock's falling edge.
        tick = (state_q != ST_IDLE) && pix_clk_q;

        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d     = ST_VBLANK;
                    blank_cnt_d = '0;
                end
            end
            ST_VBLANK: begin
                if (tick) begin
                    if (blank_cnt_q == VB_LAST) begin
                        state_d   = ST_ROW;
                        pix_cnt_d = '0;
                        row_cnt_d = '0;
                        byte_req  = 1'b1;
                    end else begin
                        blank_cnt_d = blank_cnt_q + BW'(1);
                    end
                end
            end
            ST_ROW: begin
                if (tick) begin
                    if (pix_cnt_q != PIX_LAST) begin
                        pix_cnt_d = pix_cnt_q + PW'(1);
                        byte_req  = 1'b1;
                    end else if (row_cnt_q == ROW_LAST) begin
                        state_d = ST_FRAME_END;
                    end else begin
                        state_d     = ST_HBLANK;
                        row_cnt_d   = row_cnt_q + RW'(1);
                        blank_cnt_d = '0;
                    end
                end
            end
            ST_HBLANK: begin
                if (tick) begin
                    if (blank_cnt_q == HB_LAST) begin
                        state_d   = ST_ROW;
                        pix_cnt_d = '0;
                        byte_req  = 1'b1;
                    end else begin
                        blank_cnt_d = blank_cnt_q + BW'(1);
                    end
                end
            end
            ST_FRAME_END: begin
                // Lasts one clk on the pixel clock's rising half, so the
                // blank spacing between frames is exactly VBLANK periods.
                frame_inc   = 1'b1;
                blank_cnt_d = '0;
                state_d     = i_enable ? ST_VBLANK : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (tick) begin
            hsync_d    = byte_req;
            pix_data_d = byte_req ? feed_byte : '0;
            vsync_d    = (state_d == ST_ROW) || (state_d == ST_HBLANK);
        end

        pix_clk_d = ((state_q != ST_IDLE) && (state_d != ST_IDLE)) ? ~pix_clk_q : 1'b0;

        underrun_d  = i_reset_counts ? 1'b0 : (underrun_q | feed_underrun);
        frame_cnt_d = i_reset_counts ? '0 : (frame_cnt_q + FRAME_W'(frame_inc));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pix_clk_q   <= 1'b0;
            pix_cnt_q   <= '0;
            row_cnt_q   <= '0;
            blank_cnt_q <= '0;
            vsync_q     <= 1'b0;
            hsync_q     <= 1'b0;
            pix_data_q  <= '0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pix_clk_q   <= pix_clk_d;
            pix_cnt_q   <= pix_cnt_d;
            row_cnt_q   <= row_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            vsync_q     <= vsync_d;
            hsync_q     <= hsync_d;
            pix_data_q  <= pix_data_d;
            underrun_q  <= underrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_pix_clk     = pix_clk_q;
    assign o_vsync       = vsync_q;
    assign o_hsync       = hsync_q;
    assign o_pix_data    = pix_data_q;
    assign o_underrun    = underrun_q;
    assign o_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_sf_camera_emitter.sv
// Directed bench for sf_camera_emitter: FIFO block model, negedge bus monitor,
// hand-computed byte streams and framing counts.
module tb_sf_camera_emitter;

    localparam int VB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_reset_counts = 1'b0;
    logic        o_busy, o_underrun;
    logic [31:0] o_frame_count;
    logic        i_rfifo_ready;
    logic        o_rfifo_activate, o_rfifo_strobe;
    logic [31:0] i_rfifo_data;
    logic [23:0] i_rfifo_size;
    logic        o_pix_clk, o_vsync, o_hsync;
    logic [7:0]  o_pix_data;

    always #5 clk = ~clk;

    sf_camera_emitter dut (
        .clk              (clk),
        .rst              (rst),
        .i_enable         (i_enable),
        .i_reset_counts   (i_reset_counts),
        .o_busy           (o_busy),
        .o_underrun       (o_underrun),
        .o_frame_count    (o_frame_count),
        .i_rfifo_ready    (i_rfifo_ready),
        .o_rfifo_activate (o_rfifo_activate),
        .o_rfifo_strobe   (o_rfifo_strobe),
        .i_rfifo_data     (i_rfifo_data),
        .i_rfifo_size     (i_rfifo_size),
        .o_pix_clk        (o_pix_clk),
        .o_vsync          (o_vsync),
        .o_hsync          (o_hsync),
        .o_pix_data       (o_pix_data)
    );

    // FIFO model: blocks are contiguous slices of words[], handed out in order.
    logic [31:0] words [64];
    logic [23:0] sizes [8];
    int          nblk = 0;
    logic        fifo_clr = 1'b0;
    int          blk_idx = 0, rd_ptr = 0;
    int          strobe_cnt = 0, act_pulses = 0, act_w = 0;
    logic        act_prev = 1'b0;
    int          act_widths[$];

    assign i_rfifo_ready = (blk_idx < nblk);
    assign i_rfifo_size  = (blk_idx < nblk) ? sizes[blk_idx[2:0]] : 24'd0;
    assign i_rfifo_data  = words[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (fifo_clr) begin
            blk_idx <= 0;
            rd_ptr  <= 0;
        end else begin
            if (o_rfifo_strobe) rd_ptr <= rd_ptr + 1;
            if (o_rfifo_activate && !act_prev) blk_idx <= blk_idx + 1;
        end
        if (o_rfifo_strobe) strobe_cnt <= strobe_cnt + 1;
        if (o_rfifo_activate && !act_prev) act_pulses <= act_pulses + 1;
        if (o_rfifo_activate) act_w <= act_w + 1;
        else if (act_w != 0) begin
            act_widths.push_back(act_w);
            act_w <= 0;
        end
        act_prev <= o_rfifo_activate;
    end

    // Bus monitor: one sample per pixel period, while o_pix_clk is high.
    logic [7:0] cap[$];
    int         vgaps[$];
    int         vs_rises = 0, hlow_run = 0, vlow_run = 0, last_hgap = 0;
    int         blank_bad = 0, frame_bad = 0;
    logic       vs_prev = 1'b0;

    always @(negedge clk) begin
        if (o_pix_clk && o_busy) begin
            if (o_hsync) begin
                cap.push_back(o_pix_data);
                if (hlow_run > 0) last_hgap = hlow_run;
                hlow_run = 0;
                if (!o_vsync) frame_bad++;
            end else begin
                if (o_pix_data != 8'h00) blank_bad++;
                if (o_vsync) hlow_run++;
            end
            if (o_vsync && !vs_prev) begin
                vs_rises++;
                vgaps.push_back(vlow_run);
                vlow_run = 0;
            end
            if (!o_vsync) vlow_run++;
            vs_prev = o_vsync;
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_ramp(input int nwords);
        for (int i = 0; i < 64; i++) begin
            words[i] = (i < nwords) ? {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)} : 32'hDEAD_BEEF;
        end
    endtask

    // Holds reset for two clocks, reloads the FIFO model, releases on a negedge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        fifo_clr = 1'b1;
        repeat (2) @(negedge clk);
        fifo_clr = 1'b0;
        rst = 1'b1;
    endtask

    task automatic start_frame(input string tag, input bit chk_lat);
        int lat = 0;
        i_enable = 1'b1;
        while (!o_hsync && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (chk_lat) chk({tag, "_latency"}, 32'(lat), 32'(1 + 2*VB));
        else chk({tag, "_row_start"}, 32'(o_hsync), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy && n < 800) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    task automatic check_bytes(input string tag, input int base, input int n, input bit zeros);
        chk({tag, "_nbytes"}, 32'(cap.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < cap.size())
                chk($sformatf("%s_byte%0d", tag, i), 32'(cap[base+i]), zeros ? 32'd0 : 32'(i & 8'hFF));
        end
    endtask

    int base, r0, p0, s0, w0, g0, n;

    initial begin
        // Reset state
        #1;
        chk("rst_outs", 32'({o_pix_clk, o_vsync, o_hsync, o_pix_data, o_busy,
                             o_rfifo_activate, o_rfifo_strobe, o_underrun}), 32'd0);
        chk("rst_frames", o_frame_count, 32'd0);

        // A: single block of 4 words, one frame
        load_ramp(4); sizes[0] = 24'd4; nblk = 1;
        r0 = vs_rises; p0 = act_pulses; s0 = strobe_cnt;
        do_reset();
        repeat (6) @(negedge clk);
        chk("a_prefetch_act", 32'(act_pulses - p0), 32'd1);
        base = cap.size();
        start_frame("a", 1'b1);
        @(negedge clk); i_enable = 1'b0;
        wait_idle("a");
        check_bytes("a", base, 16, 1'b0);
        chk("a_hgap", 32'(last_hgap), 32'd4);
        chk("a_frames", o_frame_count, 32'd1);
        chk("a_vsync", 32'(vs_rises - r0), 32'd1);
        chk("a_act", 32'(act_pulses - p0), 32'd1);
        chk("a_strobes", 32'(strobe_cnt - s0), 32'd4);
        chk("a_underrun", 32'(o_underrun), 32'd0);
        chk("a_pixclk_idle", 32'(o_pix_clk), 32'd0);

        // B: blocks of 1 and 3 words give the same stream
        sizes[0] = 24'd1; sizes[1] = 24'd3; nblk = 2;
        p0 = act_pulses; s0 = strobe_cnt;
        do_reset();
        repeat (8) @(negedge clk);
        base = cap.size();
        start_frame("b", 1'b1);
        @(negedge clk); i_enable = 1'b0;
        wait_idle("b");
        check_bytes("b", base, 16, 1'b0);
        chk("b_act", 32'(act_pulses - p0), 32'd2);
        chk("b_strobes", 32'(strobe_cnt - s0), 32'd4);
        chk("b_frames", o_frame_count, 32'd1);
        chk("b_underrun", 32'(o_underrun), 32'd0);

        // C: empty FIFO, framing continues with zero bytes
        nblk = 0;
        do_reset();
        repeat (4) @(negedge clk);
        base = cap.size();
        start_frame("c", 1'b1);
        @(negedge clk); i_enable = 1'b0;
        wait_idle("c");
        check_bytes("c", base, 16, 1'b1);
        chk("c_hgap", 32'(last_hgap), 32'd4);
        chk("c_underrun", 32'(o_underrun), 32'd1);
        chk("c_frames", o_frame_count, 32'd1);
        i_reset_counts = 1'b1;
        @(negedge clk); i_reset_counts = 1'b0;
        chk("c_clr_underrun", 32'(o_underrun), 32'd0);
        chk("c_clr_frames", o_frame_count, 32'd0);

        // D: three back-to-back frames from one 12-word block
        load_ramp(12); sizes[0] = 24'd12; nblk = 1;
        r0 = vs_rises;
        do_reset();
        repeat (6) @(negedge clk);
        base = cap.size(); g0 = vgaps.size();
        start_frame("d", 1'b1);
        n = 0;
        while ((vs_rises - r0) < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("d_third_frame", 32'(vs_rises - r0), 32'd3);
        i_enable = 1'b0;
        wait_idle("d");
        check_bytes("d", base, 48, 1'b0);
        chk("d_frames", o_frame_count, 32'd3);
        chk("d_vsync", 32'(vs_rises - r0), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (g0 + k < vgaps.size()) chk($sformatf("d_vgap%0d", k), 32'(vgaps[g0+k]), 32'(VB));
        end
        chk("d_underrun", 32'(o_underrun), 32'd0);

        // E: async reset in the middle of row 1
        load_ramp(4); sizes[0] = 24'd4; nblk = 1;
        do_reset();
        repeat (6) @(negedge clk);
        base = cap.size();
        start_frame("e", 1'b1);
        n = 0;
        while ((cap.size() - base) < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("e_in_row1", 32'(cap.size() - base), 32'd10);
        chk("e_act_before", 32'(o_rfifo_activate), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("e_async_outs", 32'({o_pix_clk, o_vsync, o_hsync, o_pix_data, o_busy,
                                 o_rfifo_activate, o_rfifo_strobe, o_underrun}), 32'd0);
        chk("e_async_frames", o_frame_count, 32'd0);
        p0 = act_pulses;
        do_reset();
        base = cap.size();
        start_frame("e2", 1'b1);
        @(negedge clk); i_enable = 1'b0;
        wait_idle("e2");
        check_bytes("e2", base, 16, 1'b0);
        chk("e2_act", 32'(act_pulses - p0), 32'd1);
        chk("e2_frames", o_frame_count, 32'd1);

        // F: size-0 block released at once, next block used normally
        sizes[0] = 24'd0; sizes[1] = 24'd4; nblk = 2;
        p0 = act_pulses; s0 = strobe_cnt; w0 = act_widths.size();
        do_reset();
        repeat (8) @(negedge clk);
        chk("f_act", 32'(act_pulses - p0), 32'd2);
        chk("f_strobes_pre", 32'(strobe_cnt - s0), 32'd1);
        if (w0 < act_widths.size()) chk("f_zero_width", 32'(act_widths[w0]), 32'd1);
        else chk("f_zero_width_seen", 32'(act_widths.size() - w0), 32'd1);
        base = cap.size();
        start_frame("f", 1'b1);
        @(negedge clk); i_enable = 1'b0;
        wait_idle("f");
        check_bytes("f", base, 16, 1'b0);
        chk("f_strobes", 32'(strobe_cnt - s0), 32'd4);

        chk("blank_data_zero", 32'(blank_bad), 32'd0);
        chk("hsync_in_frame", 32'(frame_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
